// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle minifloat adder/subtractor.
//
// Format is {sign, EXP_W exponent, MAN_W fraction} with bias 2^(EXP_W-1)-1.
// Subnormals are flushed to signed zero. Alignment and normalisation shift
// one bit per clock, so latency depends on the operands.
//
// Build option: define FP_ROUND_RNE_EN for round-to-nearest-even. Without it
// the result is truncated toward zero. In both cases the discarded bits still
// raise the inexact flag.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   in_valid    operands presented
//   in_ready    high only while idle
//   op_a, op_b  operands
//   sub         0: A+B, 1: A-B (sampled together with the operands)
//   out_valid   result valid; held until out_ready
//   out_ready   consumer accepts the result
//   result      sum or difference
//   flags       {invalid, overflow, inexact}, valid together with result
//   busy        operation in flight
module fp_addsub_seq #(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     op_a,
    input  logic [EXP_W+MAN_W:0]     op_b,
    input  logic                     sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     result,
    output logic [2:0]               flags,
    output logic                     busy
);

    localparam int W  = 1 + EXP_W + MAN_W;
    // Working mantissa: hidden bit, fraction, guard, round, sticky.
    localparam int MW = MAN_W + 4;
    // Adder width: working mantissa plus carry-out.
    localparam int SW = MAN_W + 5;
    localparam int CW = $clog2(MAN_W + 4);

    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W:0]   EXP_MAX  = {1'b0, EXP_ONES};
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        ALIGN,
        ADD,
        NORM,
        ROUND,
        DONE
    } state_t;

    state_t state;

    logic [W-1:0]     a_q, b_q;
    logic             sub_q;
    logic             sx, sy;
    logic [EXP_W:0]   ex;
    logic [MW-1:0]    mx, my;
    logic [CW-1:0]    shift_cnt;
    logic [SW-1:0]    sum;
    logic             rsign;
    logic [EXP_W:0]   rexp;
    logic             zero_res;
    logic             inexact_q;
    logic             special;

    // Operand decode. The latched operands stay stable for the whole
    // operation, so the special-case result can be taken from here again at
    // ROUND time instead of being stored separately.
    logic               sa, sb, za, zb;
    logic [EXP_W-1:0]   ea, eb, xa, xb, diff;
    logic [MAN_W-1:0]   fa, fb;
    logic               nan_a, nan_b, inf_a, inf_b, snan;
    logic [W-2:0]       mag_a, mag_b;
    logic               a_ge_b;
    logic [MW-1:0]      ma, mb;
    logic [CW-1:0]      cnt_init;

    assign sa    = a_q[W-1];
    assign sb    = b_q[W-1] ^ sub_q;
    assign ea    = a_q[W-2:MAN_W];
    assign eb    = b_q[W-2:MAN_W];
    assign fa    = a_q[MAN_W-1:0];
    assign fb    = b_q[MAN_W-1:0];
    assign za    = (ea == '0);
    assign zb    = (eb == '0);
    assign nan_a = (ea == EXP_ONES) && (fa != '0);
    assign nan_b = (eb == EXP_ONES) && (fb != '0);
    assign inf_a = (ea == EXP_ONES) && (fa == '0);
    assign inf_b = (eb == EXP_ONES) && (fb == '0);
    assign snan  = (nan_a && !fa[MAN_W-1]) || (nan_b && !fb[MAN_W-1]);

    assign xa     = za ? '0 : ea;
    assign xb     = zb ? '0 : eb;
    assign mag_a  = za ? '0 : a_q[W-2:0];
    assign mag_b  = zb ? '0 : b_q[W-2:0];
    assign a_ge_b = (mag_a >= mag_b);
    assign ma     = za ? '0 : {1'b1, fa, 3'b000};
    assign mb     = zb ? '0 : {1'b1, fb, 3'b000};
    assign diff   = a_ge_b ? (xa - xb) : (xb - xa);

    // Beyond MAN_W+3 positions every bit of Y already sits in sticky.
    always_comb begin
        cnt_init = CW'(MAN_W + 3);
        if (int'(diff) <= MAN_W + 3) begin
            cnt_init = CW'(diff);
        end
    end

    logic           spec_hit;
    logic           spec_inv;
    logic [W-1:0]   spec_res;

    // NaN, infinity and zero+zero cases bypass the datapath.
    always_comb begin
        spec_hit = 1'b0;
        spec_inv = 1'b0;
        spec_res = '0;
        if (nan_a || nan_b) begin
            spec_hit = 1'b1;
            spec_res = QNAN;
            spec_inv = snan;
        end else if (inf_a && inf_b && (sa != sb)) begin
            spec_hit = 1'b1;
            spec_res = QNAN;
            spec_inv = 1'b1;
        end else if (inf_a) begin
            spec_hit = 1'b1;
            spec_res = {sa, EXP_ONES, {MAN_W{1'b0}}};
        end else if (inf_b) begin
            spec_hit = 1'b1;
            spec_res = {sb, EXP_ONES, {MAN_W{1'b0}}};
        end else if (za && zb) begin
            spec_hit = 1'b1;
            spec_res = {sa & sb, {(W-1){1'b0}}};
        end
    end

    // Rounding of the normalised sum. Bits [2:0] are guard, round and sticky.
    logic               inc;
    logic [MAN_W+1:0]   mant_r;
    logic [EXP_W:0]     exp_r;
    logic [MAN_W-1:0]   frac_r;
    logic               ovf;

`ifdef FP_ROUND_RNE_EN
    assign inc = sum[2] & (sum[1] | sum[0] | sum[3]);
`else
    assign inc = 1'b0;
`endif

    assign mant_r = {1'b0, sum[MW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
    assign exp_r  = rexp + {{EXP_W{1'b0}}, mant_r[MAN_W+1]};
    assign frac_r = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    assign ovf    = (exp_r >= EXP_MAX);

    // Control FSM and datapath. Special cases take one registered hop
    // through ROUND (with the datapath bypassed) so they complete in a
    // fixed two cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            flags     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sub_q     <= 1'b0;
            sx        <= 1'b0;
            sy        <= 1'b0;
            ex        <= '0;
            mx        <= '0;
            my        <= '0;
            shift_cnt <= '0;
            sum       <= '0;
            rsign     <= 1'b0;
            rexp      <= '0;
            zero_res  <= 1'b0;
            inexact_q <= 1'b0;
            special   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= op_a;
                        b_q      <= op_b;
                        sub_q    <= sub;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= UNPACK;
                    end
                end
                UNPACK: begin
                    special   <= spec_hit;
                    zero_res  <= 1'b0;
                    inexact_q <= 1'b0;
                    shift_cnt <= cnt_init;
                    if (a_ge_b) begin
                        sx <= sa;
                        ex <= {1'b0, xa};
                        mx <= ma;
                        sy <= sb;
                        my <= mb;
                    end else begin
                        sx <= sb;
                        ex <= {1'b0, xb};
                        mx <= mb;
                        sy <= sa;
                        my <= ma;
                    end
                    state <= spec_hit ? ROUND : ALIGN;
                end
                ALIGN: begin
                    if (shift_cnt != '0) begin
                        my        <= {1'b0, my[MW-1:2], my[1] | my[0]};
                        shift_cnt <= shift_cnt - 1'b1;
                    end else begin
                        state <= ADD;
                    end
                end
                ADD: begin
                    if (sx == sy) begin
                        sum <= {1'b0, mx} + {1'b0, my};
                    end else begin
                        sum <= {1'b0, mx} - {1'b0, my};
                    end
                    rexp  <= ex;
                    rsign <= sx;
                    state <= NORM;
                end
                NORM: begin
                    if (sum == '0) begin
                        zero_res <= 1'b1;
                        rsign    <= 1'b0;
                        state    <= ROUND;
                    end else if (sum[SW-1]) begin
                        sum   <= {1'b0, sum[SW-1:2], sum[1] | sum[0]};
                        rexp  <= rexp + 1'b1;
                        state <= ROUND;
                    end else if (sum[SW-2]) begin
                        state <= ROUND;
                    end else begin
                        sum  <= sum << 1;
                        rexp <= rexp - 1'b1;
                        if (rexp == {{EXP_W{1'b0}}, 1'b1}) begin
                            zero_res  <= 1'b1;
                            inexact_q <= 1'b1;
                            state     <= ROUND;
                        end
                    end
                end
                ROUND: begin
                    if (special) begin
                        result <= spec_res;
                        flags  <= {spec_inv, 2'b00};
                    end else if (zero_res) begin
                        result <= {rsign, {(W-1){1'b0}}};
                        flags  <= {2'b00, inexact_q};
                    end else if (ovf) begin
                        result <= {rsign, EXP_ONES, {MAN_W{1'b0}}};
                        flags  <= 3'b011;
                    end else begin
                        result <= {rsign, exp_r[EXP_W-1:0], frac_r};
                        flags  <= {2'b00, |sum[2:0]};
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb_fp_addsub_seq: directed self-checking bench for fp_addsub_seq with the
// default 1/4/3 format. Expected values are hand-computed minifloat results.
module tb_fp_addsub_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       sub = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] op_a = 8'h00;
    logic [7:0] op_b = 8'h00;
    logic       in_ready, out_valid, busy;
    logic [7:0] result;
    logic [2:0] flags;

    int total = 0;
    int bad = 0;

    fp_addsub_seq #(.EXP_W(4), .MAN_W(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .op_a(op_a),
        .op_b(op_b),
        .sub(sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .flags(flags),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Presents one operation, then counts cycles from the accept edge until
    // out_valid rises (bounded).
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic s,
                                 output int lat);
        int wait_cnt;
        wait_cnt = 0;
        @(negedge clk);
        while (!in_ready && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
        end
        op_a = a;
        op_b = b;
        sub = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Full operation with out_ready high: result, flags, latency, handshake.
    task automatic runOp(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic s, input logic [7:0] eres, input logic [2:0] eflags,
                         input int elat);
        int lat;
        applyStimulus(a, b, s, lat);
        checkOutput({tag, ".res"}, 32'(result), 32'(eres));
        checkOutput({tag, ".flags"}, 32'(flags), 32'(eflags));
        if (elat > 0) begin
            checkOutput({tag, ".lat"}, 32'(lat), 32'(elat));
        end
        @(posedge clk);
        #1;
        checkOutput({tag, ".idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;

        // Reset state.
        #12;
        checkOutput("rst.in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst.out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst.busy", 32'(busy), 32'd0);
        checkOutput("rst.result", 32'(result), 32'd0);
        checkOutput("rst.flags", 32'(flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Normal path.
        runOp("one_plus_one", 8'h38, 8'h38, 1'b0, 8'h40, 3'b000, 5);
        runOp("1p5_plus_1p5", 8'h3C, 8'h3C, 1'b0, 8'h44, 3'b000, 5);
        runOp("one_minus_one", 8'h38, 8'h38, 1'b1, 8'h00, 3'b000, 5);
`ifdef FP_ROUND_RNE_EN
        runOp("align4_round", 8'h39, 8'h18, 1'b0, 8'h3A, 3'b001, 9);
`else
        runOp("align4_round", 8'h39, 8'h18, 1'b0, 8'h39, 3'b001, 9);
`endif
        runOp("two_minus_1p5", 8'h40, 8'h3C, 1'b1, 8'h30, 3'b000, 8);
        runOp("one_minus_two", 8'h38, 8'h40, 1'b1, 8'hB8, 3'b000, 7);
        runOp("overflow", 8'h77, 8'h77, 1'b0, 8'h78, 3'b011, 5);
        runOp("underflow", 8'h09, 8'h08, 1'b1, 8'h00, 3'b001, 0);

        // Special cases.
        runOp("inf_minus_inf", 8'h78, 8'h78, 1'b1, 8'h7C, 3'b100, 2);
        runOp("inf_plus_one", 8'h78, 8'h38, 1'b0, 8'h78, 3'b000, 2);
        runOp("negz_plus_negz", 8'h80, 8'h80, 1'b0, 8'h80, 3'b000, 2);
        runOp("snan", 8'h79, 8'h38, 1'b0, 8'h7C, 3'b100, 2);
        runOp("qnan", 8'h38, 8'h7C, 1'b0, 8'h7C, 3'b000, 2);

        // Back-pressure: result held, new requests ignored.
        out_ready = 1'b0;
        applyStimulus(8'h38, 8'h38, 1'b0, lat);
        checkOutput("hold.lat", 32'(lat), 32'd5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            op_a = 8'h77;
            op_b = 8'h77;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            checkOutput("hold.out_valid", 32'(out_valid), 32'd1);
            checkOutput("hold.result", 32'(result), 32'h40);
            checkOutput("hold.in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release.out_valid", 32'(out_valid), 32'd0);
        checkOutput("release.in_ready", 32'(in_ready), 32'd1);
        checkOutput("release.busy", 32'(busy), 32'd0);

        // Reset in the middle of ALIGN.
        @(negedge clk);
        op_a = 8'h39;
        op_b = 8'h18;
        sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("mid.busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst.out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst.result", 32'(result), 32'd0);
        checkOutput("midrst.flags", 32'(flags), 32'd0);
        checkOutput("midrst.in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst.busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        runOp("after_rst", 8'h3C, 8'h3C, 1'b0, 8'h44, 3'b000, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
